pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage MIPS pipeline (IF, DEC, EXE, MEM, WB). It takes hazard and wait requests from the stages and produces every stage's `pause` and `clr` strobe:

- DEC load-use pause
- EXE branch-taken
- multi-cycle mul/div busy
- data-memory handshake
- WB terminal

It holds the multi-cycle wait and halt state so that no stage register needs to track it. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_ctrl_if.sv | 42 ++++
 rtl/sat_counter.sv | 17 +
 rtl/pipe_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipe_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_MDWAIT  = 3'd1,
    ST_MEMWAIT = 3'd2,
    ST_HALT    = 3'd3
  } state_t;

  // Which strobe rule won this cycle; exported so coverage can bin on it.
  typedef enum logic [2:0] {
    PR_HALT = 3'd0,
    PR_MEM  = 3'd1,
    PR_MD   = 3'd2,
    PR_BR   = 3'd3,
    PR_LD   = 3'd4,
    PR_NONE = 3'd5
  } prio_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard requests in, stage strobes and debug status out.
interface pipe_ctrl_if #(parameter int CNT_W = pipe_pkg::CNT_W_DEFAULT);
  logic             i_PipeCtrl_ldPause;
  logic             i_PipeCtrl_brTaken;
  logic             i_PipeCtrl_mdStart;
  logic             i_PipeCtrl_mdDone;
  logic             i_PipeCtrl_memReq;
  logic             i_PipeCtrl_memAck;
  logic             i_PipeCtrl_terminalW;
  logic             o_PipeCtrl_pauseIF;
  logic             o_PipeCtrl_pauseDEC;
  logic             o_PipeCtrl_pauseEXE;
  logic             o_PipeCtrl_pauseMEM;
  logic             o_PipeCtrl_clrDEC;
  logic             o_PipeCtrl_clrEXE;
  logic             o_PipeCtrl_clrMEM;
  logic             o_PipeCtrl_clrWB;
  logic             o_PipeCtrl_halted;
  logic [2:0]       o_PipeCtrl_state;
  logic [CNT_W-1:0] o_PipeCtrl_stallCnt;
  logic [CNT_W-1:0] o_PipeCtrl_flushCnt;

  modport master (
    output i_PipeCtrl_ldPause, i_PipeCtrl_brTaken, i_PipeCtrl_mdStart,
           i_PipeCtrl_mdDone, i_PipeCtrl_memReq, i_PipeCtrl_memAck,
           i_PipeCtrl_terminalW,
    input  o_PipeCtrl_pauseIF, o_PipeCtrl_pauseDEC, o_PipeCtrl_pauseEXE,
           o_PipeCtrl_pauseMEM, o_PipeCtrl_clrDEC, o_PipeCtrl_clrEXE,
           o_PipeCtrl_clrMEM, o_PipeCtrl_clrWB, o_PipeCtrl_halted,
           o_PipeCtrl_state, o_PipeCtrl_stallCnt, o_PipeCtrl_flushCnt
  );

  modport slave (
    input  i_PipeCtrl_ldPause, i_PipeCtrl_brTaken, i_PipeCtrl_mdStart,
           i_PipeCtrl_mdDone, i_PipeCtrl_memReq, i_PipeCtrl_memAck,
           i_PipeCtrl_terminalW,
    output o_PipeCtrl_pauseIF, o_PipeCtrl_pauseDEC, o_PipeCtrl_pauseEXE,
           o_PipeCtrl_pauseMEM, o_PipeCtrl_clrDEC, o_PipeCtrl_clrEXE,
           o_PipeCtrl_clrMEM, o_PipeCtrl_clrWB, o_PipeCtrl_halted,
           o_PipeCtrl_state, o_PipeCtrl_stallCnt, o_PipeCtrl_flushCnt
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count enabled cycles, holding once every bit is set.
  always_ff @(posedge clk) begin
    if (!rstn)                 cnt <= '0;
    else if (en && (cnt != '1)) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer.
//   state   | meaning
//   RUN     | normal issue; strobes follow the per-cycle hazards
//   MDWAIT  | mul/div in progress, EXE and upstream held
//   MEMWAIT | data access outstanding, whole pipe held, WB bubbled
//   HALT    | terminal instruction retired; frozen until reset
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  pipe_ctrl_if.slave  bus
);

  state_t state, state_nxt;
  prio_t  prio;
  logic   mem_pend, md_pend;
  logic [3:0] pause;
  logic [3:0] clr;
  logic   stall_en, flush_en;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign mem_pend = bus.i_PipeCtrl_memReq && !bus.i_PipeCtrl_memAck;
  assign md_pend  = bus.i_PipeCtrl_mdStart && !bus.i_PipeCtrl_mdDone;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Next state and winning strobe rule.
  always_comb begin
    state_nxt = state;
    prio      = PR_NONE;
    // A pending memory access outranks a mul/div launch, so RUN favours MEMWAIT;
    // EXE is held meanwhile and the launch re-presents itself afterwards.
    case (state)
      ST_RUN:     if (mem_pend)                     state_nxt = ST_MEMWAIT;
                  else if (md_pend)                 state_nxt = ST_MDWAIT;
      ST_MDWAIT:  if (bus.i_PipeCtrl_mdDone)        state_nxt = mem_pend ? ST_MEMWAIT : ST_RUN;
      ST_MEMWAIT: if (bus.i_PipeCtrl_memAck)        state_nxt = ST_RUN;
      default:                                      state_nxt = ST_HALT;
    endcase
    if (bus.i_PipeCtrl_terminalW) state_nxt = ST_HALT;

    // The ack cycle itself releases the pipe, mirroring mdDone for mul/div.
    if (state == ST_HALT)                                             prio = PR_HALT;
    else if ((state == ST_MEMWAIT && !bus.i_PipeCtrl_memAck) ||
             (state == ST_RUN && mem_pend))                           prio = PR_MEM;
    else if ((state == ST_MDWAIT || bus.i_PipeCtrl_mdStart) &&
             !bus.i_PipeCtrl_mdDone)                                  prio = PR_MD;
    else if (bus.i_PipeCtrl_brTaken)                                  prio = PR_BR;
    else if (bus.i_PipeCtrl_ldPause)                                  prio = PR_LD;
  end

  // Strobe decode; pause is {IF,DEC,EXE,MEM}, clr is {DEC,EXE,MEM,WB}.
  always_comb begin
    pause = 4'b0000;
    clr   = 4'b0000;
    case (prio)
      PR_HALT: pause = 4'b1111;
      PR_MEM:  begin pause = 4'b1111; clr = 4'b0001; end
      PR_MD:   begin pause = 4'b1110; clr = 4'b0010; end
      PR_BR:   clr = 4'b1100;
      PR_LD:   begin pause = 4'b1100; clr = 4'b0100; end
      default: ;
    endcase
    if (!rstn) begin
      pause = 4'b0000;
      clr   = 4'b1111;
    end
  end

  assign stall_en = (|pause) && (state != ST_HALT);
  assign flush_en = (prio == PR_BR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk), .rstn (rstn), .en (stall_en), .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk), .rstn (rstn), .en (flush_en), .cnt (flush_cnt)
  );

  assign bus.o_PipeCtrl_pauseIF   = pause[3];
  assign bus.o_PipeCtrl_pauseDEC  = pause[2];
  assign bus.o_PipeCtrl_pauseEXE  = pause[1];
  assign bus.o_PipeCtrl_pauseMEM  = pause[0];
  assign bus.o_PipeCtrl_clrDEC    = clr[3];
  assign bus.o_PipeCtrl_clrEXE    = clr[2];
  assign bus.o_PipeCtrl_clrMEM    = clr[1];
  assign bus.o_PipeCtrl_clrWB     = clr[0];
  assign bus.o_PipeCtrl_halted    = rstn && (state == ST_HALT);
  assign bus.o_PipeCtrl_state     = state;
  assign bus.o_PipeCtrl_stallCnt  = stall_cnt;
  assign bus.o_PipeCtrl_flushCnt  = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench: a 16-bit build for sequencing, a 4-bit build for saturation.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(16)) bus_a ();
  pipe_ctrl_if #(.CNT_W(4))  bus_b ();

  pipe_ctrl #(.CNT_W(16)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
  pipe_ctrl #(.CNT_W(4))  dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

  // Strobe packing {pIF,pDEC,pEXE,pMEM,cDEC,cEXE,cMEM,cWB}.
  localparam logic [7:0] S_NONE = 8'b0000_0000;
  localparam logic [7:0] S_LD   = 8'b1100_0100;
  localparam logic [7:0] S_BR   = 8'b0000_1100;
  localparam logic [7:0] S_MD   = 8'b1110_0010;
  localparam logic [7:0] S_MEM  = 8'b1111_0001;
  localparam logic [7:0] S_HALT = 8'b1111_0000;
  localparam logic [7:0] S_RST  = 8'b0000_1111;

  // Input packing {ld,br,ms,md,mr,ma,term}.
  localparam logic [6:0] I_IDLE = 7'b0000000;
  localparam logic [6:0] I_LD   = 7'b1000000;
  localparam logic [6:0] I_BRLD = 7'b1100000;
  localparam logic [6:0] I_MS   = 7'b0010000;
  localparam logic [6:0] I_MD   = 7'b0001000;
  localparam logic [6:0] I_MSMD = 7'b0011000;
  localparam logic [6:0] I_MRBR = 7'b0100100;
  localparam logic [6:0] I_MR   = 7'b0000100;
  localparam logic [6:0] I_MRMA = 7'b0000110;
  localparam logic [6:0] I_MA   = 7'b0000010;
  localparam logic [6:0] I_MDMR = 7'b0001100;
  localparam logic [6:0] I_TERM = 7'b0000001;

  typedef struct {
    string       tag;
    logic [7:0]  strb;
    logic [2:0]  st;
    logic        halted;
    logic [15:0] stall;
    logic [15:0] flush;
    logic [3:0]  b_stall;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] strb_of_a();
    return {bus_a.o_PipeCtrl_pauseIF, bus_a.o_PipeCtrl_pauseDEC,
            bus_a.o_PipeCtrl_pauseEXE, bus_a.o_PipeCtrl_pauseMEM,
            bus_a.o_PipeCtrl_clrDEC, bus_a.o_PipeCtrl_clrEXE,
            bus_a.o_PipeCtrl_clrMEM, bus_a.o_PipeCtrl_clrWB};
  endfunction

  // Monitor: every cycle the DUTs present outputs; pop and compare at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (strb_of_a() !== e.strb) begin
        n_bad++;
        $display("FAIL %s strobes: got %b want %b", e.tag, strb_of_a(), e.strb);
      end
      n_cmp++;
      if (bus_a.o_PipeCtrl_state !== e.st) begin
        n_bad++;
        $display("FAIL %s state: got %0d want %0d", e.tag, bus_a.o_PipeCtrl_state, e.st);
      end
      n_cmp++;
      if (bus_a.o_PipeCtrl_halted !== e.halted) begin
        n_bad++;
        $display("FAIL %s halted: got %b want %b", e.tag, bus_a.o_PipeCtrl_halted, e.halted);
      end
      n_cmp++;
      if (bus_a.o_PipeCtrl_stallCnt !== e.stall) begin
        n_bad++;
        $display("FAIL %s stallCnt: got %0d want %0d", e.tag, bus_a.o_PipeCtrl_stallCnt, e.stall);
      end
      n_cmp++;
      if (bus_a.o_PipeCtrl_flushCnt !== e.flush) begin
        n_bad++;
        $display("FAIL %s flushCnt: got %0d want %0d", e.tag, bus_a.o_PipeCtrl_flushCnt, e.flush);
      end
      n_cmp++;
      if (bus_b.o_PipeCtrl_stallCnt !== e.b_stall) begin
        n_bad++;
        $display("FAIL %s sat stallCnt: got %0d want %0d", e.tag, bus_b.o_PipeCtrl_stallCnt, e.b_stall);
      end
    end
  end

  task automatic drive(input logic [6:0] v, output logic [6:0] unused);
    unused = v;
  endtask

  // One cycle: apply inputs just after the edge and queue the expected response.
  task automatic step(input string tag, input logic r, input logic [6:0] ia,
                      input logic ld_b, input logic [7:0] strb, input state_t st,
                      input logic hlt, input int stall, input int flush, input int bst);
    exp_t e;
    @(posedge clk);
    #1;
    rstn = r;
    {bus_a.i_PipeCtrl_ldPause, bus_a.i_PipeCtrl_brTaken, bus_a.i_PipeCtrl_mdStart,
     bus_a.i_PipeCtrl_mdDone, bus_a.i_PipeCtrl_memReq, bus_a.i_PipeCtrl_memAck,
     bus_a.i_PipeCtrl_terminalW} = ia;
    bus_b.i_PipeCtrl_ldPause = ld_b;
    e.tag = tag; e.strb = strb; e.st = st; e.halted = hlt;
    e.stall = 16'(stall); e.flush = 16'(flush); e.b_stall = 4'(bst);
    exp_q.push_back(e);
  endtask

  initial begin
    {bus_a.i_PipeCtrl_ldPause, bus_a.i_PipeCtrl_brTaken, bus_a.i_PipeCtrl_mdStart,
     bus_a.i_PipeCtrl_mdDone, bus_a.i_PipeCtrl_memReq, bus_a.i_PipeCtrl_memAck,
     bus_a.i_PipeCtrl_terminalW} = I_IDLE;
    {bus_b.i_PipeCtrl_ldPause, bus_b.i_PipeCtrl_brTaken, bus_b.i_PipeCtrl_mdStart,
     bus_b.i_PipeCtrl_mdDone, bus_b.i_PipeCtrl_memReq, bus_b.i_PipeCtrl_memAck,
     bus_b.i_PipeCtrl_terminalW} = I_IDLE;
    rstn = 1'b0;
    repeat (2) @(posedge clk);

    step("rst_hold",  0, I_IDLE, 0, S_RST,  ST_RUN,     0, 0, 0, 0);
    step("idle",      1, I_IDLE, 0, S_NONE, ST_RUN,     0, 0, 0, 0);
    step("ld_use",    1, I_LD,   0, S_LD,   ST_RUN,     0, 0, 0, 0);
    step("ld_after",  1, I_IDLE, 0, S_NONE, ST_RUN,     0, 1, 0, 0);
    step("br_ovr_ld", 1, I_BRLD, 0, S_BR,   ST_RUN,     0, 1, 0, 0);
    step("br_after",  1, I_IDLE, 0, S_NONE, ST_RUN,     0, 1, 1, 0);
    step("md_start",  1, I_MS,   0, S_MD,   ST_RUN,     0, 1, 1, 0);
    step("md_w1",     1, I_IDLE, 0, S_MD,   ST_MDWAIT,  0, 2, 1, 0);
    step("md_w2",     1, I_IDLE, 0, S_MD,   ST_MDWAIT,  0, 3, 1, 0);
    step("md_w3",     1, I_IDLE, 0, S_MD,   ST_MDWAIT,  0, 4, 1, 0);
    step("md_done",   1, I_MD,   0, S_NONE, ST_MDWAIT,  0, 5, 1, 0);
    step("md_back",   1, I_IDLE, 0, S_NONE, ST_RUN,     0, 5, 1, 0);
    step("md_same",   1, I_MSMD, 0, S_NONE, ST_RUN,     0, 5, 1, 0);
    step("md_same2",  1, I_IDLE, 0, S_NONE, ST_RUN,     0, 5, 1, 0);
    step("mem_br0",   1, I_MRBR, 0, S_MEM,  ST_RUN,     0, 5, 1, 0);
    step("mem_br1",   1, I_MRBR, 0, S_MEM,  ST_MEMWAIT, 0, 6, 1, 0);
    step("mem_br2",   1, I_MRBR, 0, S_MEM,  ST_MEMWAIT, 0, 7, 1, 0);
    step("mem_ack",   1, I_MRMA, 0, S_NONE, ST_MEMWAIT, 0, 8, 1, 0);
    step("mem_back",  1, I_IDLE, 0, S_NONE, ST_RUN,     0, 8, 1, 0);
    step("mem_same",  1, I_MRMA, 0, S_NONE, ST_RUN,     0, 8, 1, 0);
    step("md2mem_s",  1, I_MS,   0, S_MD,   ST_RUN,     0, 8, 1, 0);
    step("md2mem_d",  1, I_MDMR, 0, S_NONE, ST_MDWAIT,  0, 9, 1, 0);
    step("md2mem_w",  1, I_MR,   0, S_MEM,  ST_MEMWAIT, 0, 9, 1, 0);
    step("mem_mdign", 1, I_MDMR, 0, S_MEM,  ST_MEMWAIT, 0, 10, 1, 0);
    step("mem_ack2",  1, I_MA,   0, S_NONE, ST_MEMWAIT, 0, 11, 1, 0);
    step("run_again", 1, I_IDLE, 0, S_NONE, ST_RUN,     0, 11, 1, 0);
    step("term",      1, I_TERM, 0, S_NONE, ST_RUN,     0, 11, 1, 0);
    step("halt1",     1, I_IDLE, 0, S_HALT, ST_HALT,    1, 11, 1, 0);
    step("halt_br",   1, I_BRLD, 0, S_HALT, ST_HALT,    1, 11, 1, 0);
    step("halt_md",   1, I_MS,   0, S_HALT, ST_HALT,    1, 11, 1, 0);
    step("halt_rst",  0, I_IDLE, 0, S_RST,  ST_HALT,    0, 11, 1, 0);
    step("post_rst",  1, I_IDLE, 0, S_NONE, ST_RUN,     0, 0, 0, 0);

    for (int i = 0; i < 20; i++)
      step("sat_run", 1, I_IDLE, 1, S_NONE, ST_RUN, 0, 0, 0, (i < 15) ? i : 15);
    step("sat_hold", 1, I_IDLE, 0, S_NONE, ST_RUN, 0, 0, 0, 15);

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
